// File: rtl/xif_core_pkg.sv
// +----------------------------------------------------------------------------+
// | xif_core_pkg: shared defaults, FSM state and result type for xif_core_driver |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package xif_core_pkg;

  localparam int X_ID_WIDTH_DEF      = 4;
  localparam int X_RFR_WIDTH_DEF     = 32;
  localparam int X_RFW_WIDTH_DEF     = 32;
  localparam int MAX_OUTSTANDING_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [X_ID_WIDTH_DEF-1:0]  id;
    logic [X_RFW_WIDTH_DEF-1:0] data;
    logic [4:0]                 rd;
    logic                       we;
  } result_t;

endpackage

`default_nettype wire

// File: rtl/xif_id_scoreboard.sv
// +----------------------------------------------------------------------------+
// | xif_id_scoreboard: per-ID in-flight bits with set/clear, two lookups, count |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module xif_id_scoreboard
  import xif_core_pkg::*;
#(
  parameter int ID_W  = X_ID_WIDTH_DEF,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_set,
  input  logic [ID_W-1:0]  i_set_id,
  input  logic             i_clr,
  input  logic [ID_W-1:0]  i_clr_id,
  input  logic [ID_W-1:0]  i_busy_id,
  output logic             o_busy,
  input  logic [ID_W-1:0]  i_query_id,
  output logic             o_query,
  output logic [CNT_W-1:0] o_count
);

  localparam int DEPTH = 2 ** ID_W;

  logic [DEPTH-1:0] r_valid;
  logic [CNT_W-1:0] w_cnt;

  // A clear only ever targets a set bit, so set and clear never hit the same ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else begin
      if (i_clr) r_valid[i_clr_id] <= 1'b0;
      if (i_set) r_valid[i_set_id] <= 1'b1;
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + CNT_W'(r_valid[i]);
    end
  end

  assign o_busy  = r_valid[i_busy_id];
  assign o_query = r_valid[i_query_id];
  assign o_count = w_cnt;

endmodule

`default_nettype wire

// File: rtl/xif_core_driver.sv
// +----------------------------------------------------------------------------+
// | xif_core_driver: core-side eXtension Interface initiator (issue/commit/wb)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module xif_core_driver
  import xif_core_pkg::*;
#(
  parameter int X_ID_WIDTH      = X_ID_WIDTH_DEF,
  parameter int X_RFR_WIDTH     = X_RFR_WIDTH_DEF,
  parameter int X_RFW_WIDTH     = X_RFW_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [31:0]                            req_instr_i,
  input  logic [X_RFR_WIDTH-1:0]                 req_rs1_i,
  input  logic [X_RFR_WIDTH-1:0]                 req_rs2_i,
  output logic                                   issue_valid_o,
  input  logic                                   issue_ready_i,
  output logic [31:0]                            issue_instr_o,
  output logic [X_ID_WIDTH-1:0]                  issue_id_o,
  output logic [2*X_RFR_WIDTH-1:0]               issue_rs_o,
  output logic [1:0]                             issue_rs_valid_o,
  input  logic                                   issue_accept_i,
  input  logic                                   issue_writeback_i,
  output logic                                   commit_valid_o,
  output logic [X_ID_WIDTH-1:0]                  commit_id_o,
  output logic                                   commit_kill_o,
  input  logic                                   result_valid_i,
  output logic                                   result_ready_o,
  input  logic [X_ID_WIDTH-1:0]                  result_id_i,
  input  logic [X_RFW_WIDTH-1:0]                 result_data_i,
  input  logic [4:0]                             result_rd_i,
  input  logic                                   result_we_i,
  output logic                                   wb_valid_o,
  output logic [4:0]                             wb_rd_o,
  output logic [X_RFW_WIDTH-1:0]                 wb_data_o,
  output logic                                   illegal_o,
  output logic                                   err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  state_e                  r_state;
  logic [X_ID_WIDTH-1:0]   r_next_id;
  logic [31:0]             r_instr;
  logic [X_RFR_WIDTH-1:0]  r_rs1;
  logic [X_RFR_WIDTH-1:0]  r_rs2;
  logic                    r_issue_valid;
  logic                    r_commit_valid;
  logic                    r_kill;
  logic                    r_illegal;
  logic                    r_req_ready;
  logic                    r_wb_valid;
  logic [4:0]              r_wb_rd;
  logic [X_RFW_WIDTH-1:0]  r_wb_data;
  logic                    r_err;

  logic                    w_req_hs;
  logic                    w_set;
  logic                    w_hit;
  logic                    w_clr;
  logic                    w_busy;
  logic                    w_busy_next;
  logic                    w_idle_next;
  logic                    w_ready_next;
  logic [CNT_W-1:0]        w_count;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [X_ID_WIDTH-1:0]   w_next_inc;
  logic [X_ID_WIDTH-1:0]   w_chk_id;
  logic                    w_unused_wb_intent;

  // Writeback is qualified per result by result_we_i; the issue-time hint is not needed.
  assign w_unused_wb_intent = issue_writeback_i;

  assign w_req_hs   = req_valid_i && r_req_ready;
  assign w_set      = r_commit_valid && !r_kill;
  assign w_clr      = result_valid_i && w_hit;
  assign w_next_inc = r_next_id + X_ID_WIDTH'(1);

  // req_ready is registered, so it is computed from the post-edge view of the scoreboard.
  assign w_chk_id     = (r_state == COMMIT) ? w_next_inc : r_next_id;
  assign w_cnt_next   = w_count + CNT_W'(w_set) - CNT_W'(w_clr);
  assign w_busy_next  = (w_busy && !(w_clr && (result_id_i == w_chk_id))) ||
                        (w_set && (r_next_id == w_chk_id));
  assign w_idle_next  = ((r_state == IDLE) && !w_req_hs) || (r_state == COMMIT);
  assign w_ready_next = w_idle_next && (w_cnt_next < CNT_W'(MAX_OUTSTANDING)) && !w_busy_next;

  xif_id_scoreboard #(
    .ID_W  (X_ID_WIDTH),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_set      (w_set),
    .i_set_id   (r_next_id),
    .i_clr      (w_clr),
    .i_clr_id   (result_id_i),
    .i_busy_id  (w_chk_id),
    .o_busy     (w_busy),
    .i_query_id (result_id_i),
    .o_query    (w_hit),
    .o_count    (w_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_next_id      <= '0;
      r_instr        <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_issue_valid  <= 1'b0;
      r_commit_valid <= 1'b0;
      r_kill         <= 1'b0;
      r_illegal      <= 1'b0;
      r_req_ready    <= 1'b0;
    end else begin
      r_req_ready    <= w_ready_next;
      r_commit_valid <= 1'b0;
      r_kill         <= 1'b0;
      r_illegal      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_hs) begin
            r_instr       <= req_instr_i;
            r_rs1         <= req_rs1_i;
            r_rs2         <= req_rs2_i;
            r_issue_valid <= 1'b1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_ready_i) begin
            r_issue_valid  <= 1'b0;
            r_commit_valid <= 1'b1;
            r_kill         <= !issue_accept_i;
            r_illegal      <= !issue_accept_i;
            r_state        <= COMMIT;
          end
        end
        COMMIT: begin
          r_next_id <= w_next_inc;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= w_clr && result_we_i;
      r_err      <= result_valid_i && !w_hit;
      if (w_clr) begin
        r_wb_rd   <= result_rd_i;
        r_wb_data <= result_data_i;
      end
    end
  end

  assign req_ready_o      = r_req_ready;
  assign issue_valid_o    = r_issue_valid;
  assign issue_instr_o    = r_instr;
  assign issue_id_o       = r_next_id;
  assign issue_rs_o       = {r_rs2, r_rs1};
  assign issue_rs_valid_o = {2{r_issue_valid}};
  assign commit_valid_o   = r_commit_valid;
  assign commit_id_o      = r_next_id;
  assign commit_kill_o    = r_kill;
  assign result_ready_o   = 1'b1;
  assign wb_valid_o       = r_wb_valid;
  assign wb_rd_o          = r_wb_rd;
  assign wb_data_o        = r_wb_data;
  assign illegal_o        = r_illegal;
  assign err_o            = r_err;
  assign outstanding_o    = w_count;

endmodule

`default_nettype wire

// File: tb/tb_xif_core_driver.sv
// +----------------------------------------------------------------------------+
// | tb_xif_core_driver: randomized self-checking bench with in-flight ID model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_xif_core_driver;
  import xif_core_pkg::*;

  localparam int IDW  = 4;
  localparam int RW   = 32;
  localparam int WW   = 32;
  localparam int MAXO = 4;
  localparam int NID  = 16;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_instr;
  logic [RW-1:0] req_rs1;
  logic [RW-1:0] req_rs2;
  logic          issue_valid;
  logic          issue_ready;
  logic [31:0]   issue_instr;
  logic [IDW-1:0] issue_id;
  logic [2*RW-1:0] issue_rs;
  logic [1:0]    issue_rs_valid;
  logic          issue_accept;
  logic          issue_writeback;
  logic          commit_valid;
  logic [IDW-1:0] commit_id;
  logic          commit_kill;
  logic          result_valid;
  logic          result_ready;
  logic [IDW-1:0] result_id;
  logic [WW-1:0] result_data;
  logic [4:0]    result_rd;
  logic          result_we;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [WW-1:0] wb_data;
  logic          illegal;
  logic          err;
  logic [2:0]    outstanding;

  xif_core_driver #(
    .X_ID_WIDTH      (IDW),
    .X_RFR_WIDTH     (RW),
    .X_RFW_WIDTH     (WW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_instr_i       (req_instr),
    .req_rs1_i         (req_rs1),
    .req_rs2_i         (req_rs2),
    .issue_valid_o     (issue_valid),
    .issue_ready_i     (issue_ready),
    .issue_instr_o     (issue_instr),
    .issue_id_o        (issue_id),
    .issue_rs_o        (issue_rs),
    .issue_rs_valid_o  (issue_rs_valid),
    .issue_accept_i    (issue_accept),
    .issue_writeback_i (issue_writeback),
    .commit_valid_o    (commit_valid),
    .commit_id_o       (commit_id),
    .commit_kill_o     (commit_kill),
    .result_valid_i    (result_valid),
    .result_ready_o    (result_ready),
    .result_id_i       (result_id),
    .result_data_i     (result_data),
    .result_rd_i       (result_rd),
    .result_we_i       (result_we),
    .wb_valid_o        (wb_valid),
    .wb_rd_o           (wb_rd),
    .wb_data_o         (wb_data),
    .illegal_o         (illegal),
    .err_o             (err),
    .outstanding_o     (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which IDs are in flight and which ID the next request gets.
  bit inflight[NID];
  int m_next;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NID; i++) c += inflight[i];
    return c;
  endfunction

  function automatic bit m_ready();
    return (m_count() < MAXO) && !inflight[m_next];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NID; i++) inflight[i] = 1'b0;
    m_next = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready",   req_ready, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_rs_valid",    issue_rs_valid, 0);
    chk("rst_issue_id",    issue_id, 0);
    chk("rst_issue_instr", issue_instr, 0);
    chk("rst_issue_rs",    issue_rs, 0);
    chk("rst_commit",      commit_valid, 0);
    chk("rst_commit_id",   commit_id, 0);
    chk("rst_kill",        commit_kill, 0);
    chk("rst_result_rdy",  result_ready, 1);
    chk("rst_wb_valid",    wb_valid, 0);
    chk("rst_wb_rd",       wb_rd, 0);
    chk("rst_wb_data",     wb_data, 0);
    chk("rst_illegal",     illegal, 0);
    chk("rst_err",         err, 0);
    chk("rst_outstanding", outstanding, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Called one cycle after a result was presented; hit is the model's view before that edge.
  task automatic result_effect(input bit hit, input bit we, input logic [4:0] rd, input logic [31:0] data);
    if (hit) begin
      chk("wb_valid", wb_valid, we);
      if (we) begin
        chk("wb_rd",   wb_rd, rd);
        chk("wb_data", wb_data, data);
      end
      chk("err_on_hit", err, 0);
    end else begin
      chk("err_on_miss", err, 1);
      chk("wb_on_miss",  wb_valid, 0);
    end
  endtask

  task automatic send_result(input int id, input logic [31:0] data, input logic [4:0] rd, input bit we);
    bit hit;
    hit          = inflight[id];
    result_valid = 1'b1;
    result_id    = IDW'(id);
    result_data  = data;
    result_rd    = rd;
    result_we    = we;
    @(negedge clk);
    result_valid = 1'b0;
    if (hit) inflight[id] = 1'b0;
    result_effect(hit, we, rd, data);
    chk("res_outstanding", outstanding, m_count());
    chk("res_req_ready",   req_ready, m_ready());
  endtask

  task automatic do_op(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                       input int stall, input bit acc, input bit co, input int co_id,
                       output int id_out);
    int w;
    bit hit;
    logic [31:0] cd;
    logic [4:0]  crd;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      chk("req_ready_timeout", 0, 1);
      id_out = -1;
      return;
    end
    id_out    = m_next;
    req_valid = 1'b1;
    req_instr = instr;
    req_rs1   = rs1;
    req_rs2   = rs2;
    @(negedge clk);
    req_valid = 1'b0;
    req_instr = $urandom;
    req_rs1   = $urandom;
    req_rs2   = $urandom;
    for (int s = 0; s <= stall; s++) begin
      chk("issue_valid", issue_valid, 1);
      chk("issue_instr", issue_instr, instr);
      chk("issue_id",    issue_id, m_next);
      chk("issue_rs",    issue_rs, {rs2, rs1});
      chk("issue_rs_vld", issue_rs_valid, 2'b11);
      chk("early_commit", commit_valid, 0);
      chk("busy_ready",  req_ready, 0);
      if (s == stall) begin
        issue_ready  = 1'b1;
        issue_accept = acc;
      end else begin
        issue_accept = 1'($urandom);
      end
      issue_writeback = 1'($urandom);
      @(negedge clk);
    end
    issue_ready = 1'b0;
    chk("commit_valid", commit_valid, 1);
    chk("commit_id",    commit_id, m_next);
    chk("commit_kill",  commit_kill, !acc);
    chk("illegal",      illegal, !acc);
    chk("issue_dropped", issue_valid, 0);
    hit = 1'b0;
    cd  = $urandom;
    crd = 5'($urandom);
    if (co) begin
      hit          = inflight[co_id];
      result_valid = 1'b1;
      result_id    = IDW'(co_id);
      result_data  = cd;
      result_rd    = crd;
      result_we    = 1'b1;
    end
    @(negedge clk);
    result_valid = 1'b0;
    if (co) begin
      if (hit) inflight[co_id] = 1'b0;
      result_effect(hit, 1'b1, crd, cd);
    end
    if (acc) inflight[m_next] = 1'b1;
    m_next = (m_next + 1) % NID;
    chk("commit_pulse", commit_valid, 0);
    chk("illegal_pulse", illegal, 0);
    chk("op_outstanding", outstanding, m_count());
    chk("op_req_ready", req_ready, m_ready());
  endtask

  task automatic drain();
    for (int i = 0; i < NID; i++) begin
      if (inflight[i]) send_result(i, $urandom, 5'($urandom), 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    int ids[4];
    int pick;
    rst_n = 1'b0;
    req_valid = 1'b0; req_instr = '0; req_rs1 = '0; req_rs2 = '0;
    issue_ready = 1'b0; issue_accept = 1'b0; issue_writeback = 1'b0;
    result_valid = 1'b0; result_id = '0; result_data = '0; result_rd = '0; result_we = 1'b0;
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    // Single accepted op followed by its result.
    do_op(32'h0000_500B, 32'h1111_1111, 32'h2222_2222, 0, 1'b1, 1'b0, 0, id);
    chk("first_id", id, 0);
    chk("outstanding_one", outstanding, 1);
    send_result(0, 32'hDEAD_BEEF, 5'd5, 1'b1);
    chk("outstanding_zero", outstanding, 0);

    // Rejected op, then the following request takes the next ID.
    do_op(32'h1234_5678, 32'h3, 32'h4, 0, 1'b0, 1'b0, 0, id);
    chk("reject_id", id, 1);
    chk("reject_outstanding", outstanding, 0);

    // Backpressure on issue for 5 cycles.
    do_op(32'hCAFE_F00D, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5, 1'b1, 1'b0, 0, id);
    chk("bp_id", id, 2);

    // Spurious result for an ID never issued.
    send_result(7, 32'h7777_7777, 5'd7, 1'b1);
    chk("spurious_keeps_count", outstanding, 1);
    drain();

    // Outstanding limit.
    for (int k = 0; k < 4; k++) begin
      do_op($urandom, $urandom, $urandom, 0, 1'b1, 1'b0, 0, id);
      ids[k] = id;
    end
    for (int k = 0; k < 3; k++) begin
      chk("full_not_ready", req_ready, 0);
      @(negedge clk);
    end
    send_result(ids[1], 32'h0BAD_F00D, 5'd9, 1'b1);
    chk("ready_after_retire", req_ready, 1);
    drain();

    // Commit and retire of a different ID in the same cycle; then a result racing its own commit.
    do_op($urandom, $urandom, $urandom, 0, 1'b1, 1'b0, 0, id);
    do_op($urandom, $urandom, $urandom, 1, 1'b1, 1'b1, id, pick);
    chk("same_cycle_count", outstanding, 1);
    do_op($urandom, $urandom, $urandom, 0, 1'b1, 1'b1, m_next, id);
    drain();

    // ID wrap with id 0 held across the wrap.
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      do_op($urandom, $urandom, $urandom, 0, 1'b1, 1'b0, 0, id);
      chk("wrap_id", id, k % NID);
      if (k < 16) send_result(id, $urandom, 5'($urandom), 1'b1);
    end
    for (int k = 1; k < 16; k++) begin
      do_op($urandom, $urandom, $urandom, 0, 1'b1, 1'b0, 0, id);
      send_result(id, $urandom, 5'($urandom), 1'($urandom));
    end
    for (int k = 0; k < 3; k++) begin
      chk("collision_stall", req_ready, 0);
      @(negedge clk);
    end
    send_result(0, 32'h0000_0ACE, 5'd1, 1'b1);
    do_op($urandom, $urandom, $urandom, 0, 1'b1, 1'b0, 0, id);
    chk("post_collision_id", id, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      if (!m_ready() || $urandom_range(0, 3) == 0) begin
        if (m_count() > 0 && (!m_ready() || $urandom_range(0, 3) != 0)) begin
          pick = $urandom_range(0, NID - 1);
          while (!inflight[pick]) pick = (pick + 1) % NID;
        end else begin
          pick = $urandom_range(0, NID - 1);
        end
        send_result(pick, $urandom, 5'($urandom), 1'($urandom));
      end else begin
        do_op($urandom, $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) == 0), $urandom_range(0, NID - 1), id);
      end
    end

    // Asynchronous reset while an issue is pending.
    if (!m_ready()) drain();
    if (m_count() == 0) do_op($urandom, $urandom, $urandom, 0, 1'b1, 1'b0, 0, id);
    chk("pre_reset_ready", req_ready, 1);
    req_valid = 1'b1;
    req_instr = 32'hFFFF_0001;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_reset_issue", issue_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    issue_ready = 1'b1;
    issue_accept = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_commit_after_reset", commit_valid, 0);
      chk("no_issue_after_reset", issue_valid, 0);
    end
    issue_ready = 1'b0;
    chk("reset_outstanding", outstanding, 0);
    chk("reset_ready", req_ready, 1);
    do_op($urandom, $urandom, $urandom, 0, 1'b1, 1'b0, 0, id);
    chk("reset_next_id", id, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xif_core_driver.md
Name: xif_core_driver

Overview:
- Core-side initiator of the eXtension Interface. It is the partner for xif_copro in integration and unit benches, standing in for a CV-X-IF-capable core.
- Accepts offload requests (instruction plus rs1/rs2 operands) on a valid/ready port and drives the issue handshake.
- Sends one commit (or kill) per issued ID, tracks outstanding IDs in a scoreboard, collects results and presents register writebacks.

Parameters:
- X_ID_WIDTH, 4, width of the instruction ID; the ID space is 2**X_ID_WIDTH.
- X_RFR_WIDTH, 32, width of each source register operand.
- X_RFW_WIDTH, 32, width of the result data.
- MAX_OUTSTANDING, 4, maximum number of accepted instructions awaiting a result (1..2**X_ID_WIDTH).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  offload request valid
- req_ready_o  out  1  request accepted this cycle when valid && ready
- req_instr_i  in  32  instruction word
- req_rs1_i  in  X_RFR_WIDTH  rs1 operand
- req_rs2_i  in  X_RFR_WIDTH  rs2 operand
- issue_valid_o  out  1  issue request valid
- issue_ready_i  in  1  coprocessor issue ready
- issue_instr_o  out  32  issued instruction
- issue_id_o  out  X_ID_WIDTH  issued ID
- issue_rs_o  out  2*X_RFR_WIDTH  {rs2, rs1}
- issue_rs_valid_o  out  2  always 2'b11 while issue_valid_o is high
- issue_accept_i  in  1  response: instruction accepted
- issue_writeback_i  in  1  response: instruction will write rd
- commit_valid_o  out  1  commit strobe
- commit_id_o  out  X_ID_WIDTH  committed ID
- commit_kill_o  out  1  kill flag for the committed ID
- result_valid_i  in  1  result valid
- result_ready_o  out  1  result ready
- result_id_i  in  X_ID_WIDTH  result ID
- result_data_i  in  X_RFW_WIDTH  result data
- result_rd_i  in  5  destination register
- result_we_i  in  1  write enable
- wb_valid_o  out  1  registered writeback strobe
- wb_rd_o  out  5  writeback register
- wb_data_o  out  X_RFW_WIDTH  writeback data
- illegal_o  out  1  one-cycle pulse: issue rejected
- err_o  out  1  one-cycle pulse: result for an ID not in flight
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count

Behaviour:
- Reset: FSM is IDLE, next_id = 0, scoreboard is empty. All outputs are 0 except result_ready_o = 1.
- FSM states: IDLE, ISSUE, COMMIT.
- IDLE: req_ready_o = 1 only when outstanding < MAX_OUTSTANDING and scoreboard[next_id] == 0. On a request handshake, latch instr/rs1/rs2 and assign next_id, then go to ISSUE.
- ISSUE: issue_valid_o = 1. All payload stays stable until issue_ready_i. On the handshake, sample issue_accept_i and issue_writeback_i, then go to COMMIT.
- COMMIT: commit_valid_o = 1 for exactly one cycle with commit_id_o = the issued ID and commit_kill_o = !accept.
  - If accepted: set the scoreboard bit.
  - If not accepted: pulse illegal_o in the same cycle and set no scoreboard bit.
  - In both cases next_id increments modulo 2**X_ID_WIDTH (15 -> 0 when X_ID_WIDTH = 4). Return to IDLE.
- Minimum request-to-request spacing is 3 cycles. Issue-to-commit latency is exactly 1 cycle after the issue handshake.
- Results: result_ready_o is constant 1.
  - On result_valid_i with scoreboard[result_id_i] set: clear the bit. Next cycle, wb_valid_o = result_we_i, with wb_rd_o and wb_data_o registered from the result.
  - Result for an unset ID: pulse err_o next cycle, no writeback, scoreboard unchanged.
- Simultaneous set (COMMIT) and clear (result) of different IDs in one cycle: both take effect. outstanding_o is unchanged.
- A result for the ID being committed in the same cycle is an error. The scoreboard bit is not yet set, so err_o pulses.
- ID collision: the wrapped next_id is still in flight, so req_ready_o holds 0 until that ID retires.
- Reset mid-operation clears the FSM, scoreboard, counters and pulses immediately (asynchronous). No commit is emitted for a pending issue.

Decomposition:
- Shared package xif_core_pkg holds: X_ID_WIDTH, X_RFR_WIDTH and X_RFW_WIDTH defaults; the state enum (IDLE/ISSUE/COMMIT); and a result struct {id, data, rd, we}.
- Sub-module xif_id_scoreboard: 2**X_ID_WIDTH valid bits with set/clear ports, a busy query on next_id, a query on result_id, and a popcount output.

Test Plan:
- Single accepted op: issue_ready_i and accept = 1 -> commit id 0, kill 0. Result {id 0, data 0xDEADBEEF, rd 5, we 1} -> wb_valid_o next cycle with rd 5, data 0xDEADBEEF; outstanding 1 -> 0.
- Rejected op: accept = 0 -> commit_kill_o = 1, illegal_o pulses one cycle, outstanding_o stays 0, next request gets id 1.
- Backpressure: issue_ready_i low for 5 cycles -> issue_valid_o held with instr/id/rs stable; commit occurs exactly 1 cycle after ready.
- Outstanding limit with MAX_OUTSTANDING = 4: 4 accepted and no results -> req_ready_o = 0. Result id 2 -> req_ready_o returns 1 next cycle.
- ID wrap: 17 accepted ops with results returned immediately -> IDs 0..15, 0. Hold id 0 unresolved across the wrap -> req_ready_o stalls at next_id = 0.
- Spurious result with id 7 never issued -> err_o pulses, no wb_valid_o, scoreboard unchanged. Reset asserted in ISSUE -> all outputs reset, no commit.
